// File: rtl/data_sram_like_slave.sv
// Data SRAM-like bus responder: addr_ok acceptance, byte-masked writes, in-order fixed-latency responses.
// Optional LFSR-driven acceptance stall is compiled in when DSRAM_STALL_EN is defined.
module data_sram_like_slave #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int DEPTH = 1 << ADDR_W;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [CNT_W-1:0]             count_r;
  logic [LATENCY-1:0]           valid_r;
  logic [LATENCY-1:0][31:0]     data_r;
  logic [31:0]                  mem_r [DEPTH];
  logic [ADDR_W-1:0]            widx_s;
  logic [31:0]                  rd_word_s;
  logic                         stall_s;
  logic                         accept_s;
  logic                         retire_s;
  logic                         unused_s;

  assign widx_s    = data_sram_addr[ADDR_W+1:2];
  assign rd_word_s = mem_r[widx_s];
  assign unused_s  = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

`ifdef DSRAM_STALL_EN
  logic [15:0] lfsr_r;
  logic        lfsr_fb_s;

  assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
  assign stall_s   = (lfsr_r[1:0] == 2'b00);

  // Free-running Fibonacci LFSR that paces acceptance stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
    end
  end
`else
  assign stall_s = 1'b0;
`endif

  // A slot freed by a response this cycle only becomes usable next cycle.
  assign data_sram_addr_ok = data_sram_req && (count_r < CNT_W'(MAX_OUT)) && !stall_s;
  assign accept_s          = data_sram_req && data_sram_addr_ok;
  assign retire_s          = valid_r[LATENCY-1];

  // Outstanding request counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (accept_s && !retire_s) begin
      count_r <= count_r + CNT_W'(1);
    end else if (!accept_s && retire_s) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Response pipeline; write entries carry zero data so rdata is zero outside read responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
      data_r  <= '0;
    end else begin
      valid_r[0] <= accept_s;
      data_r[0]  <= (accept_s && !data_sram_wr) ? rd_word_s : 32'h0000_0000;
      for (int k = 1; k < LATENCY; k++) begin
        valid_r[k] <= valid_r[k-1];
        data_r[k]  <= data_r[k-1];
      end
    end
  end

  // Memory array, deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (accept_s && data_sram_wr) begin
      mem_r[widx_s] <= merge_lanes(mem_r[widx_s], data_sram_wdata, data_sram_wstrb);
    end
  end

  assign data_sram_data_ok = valid_r[LATENCY-1];
  assign data_sram_rdata   = data_r[LATENCY-1];

  data_sram_like_slave_chk #(
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CNT_W)
  ) u_chk (
    .clk     (clk),
    .reset   (reset),
    .count   (count_r),
    .data_ok (data_sram_data_ok),
    .rdata   (data_sram_rdata)
  );

endmodule

// Invariant checker for the responder's occupancy and response outputs.
module data_sram_like_slave_chk #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3
) (
  input logic             clk,
  input logic             reset,
  input logic [CNT_W-1:0] count,
  input logic             data_ok,
  input logic [31:0]      rdata
);

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count <= CNT_W'(MAX_OUT));

  a_rdata_idle_zero: assert property (@(posedge clk) disable iff (reset)
    !data_ok |-> (rdata == 32'h0000_0000));

  a_resp_has_owner: assert property (@(posedge clk) disable iff (reset)
    data_ok |-> (count != '0));

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Self-checking bench for data_sram_like_slave: vector table, hand sequences and random traffic vs a queue model.
// LATENCY=3 / MAX_OUT=2 so that the outstanding limit is actually reachable.
module tb_data_sram_like_slave;

  localparam int AW  = 10;
  localparam int LAT = 3;
  localparam int MO  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  data_sram_like_slave #(
    .ADDR_W  (AW),
    .LATENCY (LAT),
    .MAX_OUT (MO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_size    (size),
    .data_sram_wstrb   (wstrb),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  resp_t       exp_q[$];
  logic [31:0] mem_m [1 << AW];
  logic [15:0] lfsr_m;
  int          cyc_n;
  int          n_cmp;
  int          n_err;
  logic        last_aok;
  logic        last_dok;
  logic [31:0] last_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic logic stall_now();
`ifdef DSRAM_STALL_EN
    return (lfsr_m[1:0] == 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // One bus cycle: drive at negedge, compare mid-cycle, advance the model across the posedge.
  task automatic cyc(input logic r, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    logic        exp_aok;
    logic        exp_dok;
    logic [31:0] exp_rd;
    int          idx;
    resp_t       e;
    req = r; wr = w; wstrb = s; addr = a; wdata = d; size = 2'($urandom_range(0, 2));
    #2;
    exp_aok = r && (exp_q.size() < MO) && !stall_now();
    exp_dok = (exp_q.size() > 0) && (exp_q[0].due == cyc_n);
    exp_rd  = exp_dok ? exp_q[0].data : 32'h0;
    chk("addr_ok", {31'h0, addr_ok}, {31'h0, exp_aok});
    chk("data_ok", {31'h0, data_ok}, {31'h0, exp_dok});
    chk("rdata", rdata, exp_rd);
    last_aok = exp_aok;
    last_dok = data_ok;
    last_rd  = rdata;
    if (exp_dok) void'(exp_q.pop_front());
    if (exp_aok) begin
      idx    = int'(a[AW+1:2]);
      e.data = w ? 32'h0 : mem_m[idx];
      e.due  = cyc_n + LAT;
      exp_q.push_back(e);
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (s[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
        end
      end
    end
    @(posedge clk);
    cyc_n++;
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Hold the request until accepted; the limit bounds a stuck addr_ok.
  task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    int tries;
    tries = 0;
    do begin
      cyc(1'b1, w, s, a, d);
      tries++;
    end while (!last_aok && tries < 32);
    if (!last_aok) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: got no accept expected accept within 32 cycles (addr %h)", a);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 1'b0; wr = 1'b0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0; size = 2'd0;
    repeat (2) @(posedge clk);
    cyc_n += 2;
    @(negedge clk);
    chk("reset_data_ok", {31'h0, data_ok}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_addr_ok", {31'h0, addr_ok}, 32'h0);
    reset = 1'b0;
    exp_q.delete();
    lfsr_m = 16'hACE1;
  endtask

  // Issue one transaction, then confirm its response latency and data against the table.
  task automatic run_vec(input string nm, input vec_t v);
    int          got;
    logic [31:0] got_rd;
    issue(v.wr, v.strb, v.addr, v.wdata);
    got    = -1;
    got_rd = 32'h0;
    for (int k = 1; k <= LAT + 3; k++) begin
      idle();
      if (last_dok === 1'b1 && got < 0) begin
        got    = k;
        got_rd = last_rd;
      end
    end
    chk({nm, "_latency"}, 32'(got), 32'(LAT));
    chk({nm, "_rdata"}, got_rd, v.exp_rdata);
  endtask

  vec_t        tbl [12];
  logic [31:0] sat_exp [6];
  logic [31:0] got_q[$];
  int          k;
  int          guard;
  logic [31:0] ra;

  initial begin
    n_cmp = 0; n_err = 0; cyc_n = 0; lfsr_m = 16'hACE1;
    reset = 1'b1; req = 1'b0; wr = 1'b0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0; size = 2'd0;

    tbl[0]  = '{1'b1, 4'hF,    32'h0000_0010, 32'h1122_3344, 32'h0000_0000};
    tbl[1]  = '{1'b0, 4'hF,    32'h0000_0010, 32'h0000_0000, 32'h1122_3344};
    tbl[2]  = '{1'b1, 4'b0100, 32'h0000_0010, 32'h00AA_0000, 32'h0000_0000};
    tbl[3]  = '{1'b0, 4'h0,    32'h0000_0010, 32'h0000_0000, 32'h11AA_3344};
    tbl[4]  = '{1'b1, 4'h0,    32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[5]  = '{1'b0, 4'hF,    32'h0000_0010, 32'h0000_0000, 32'h11AA_3344};
    tbl[6]  = '{1'b1, 4'hF,    32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0000};
    tbl[7]  = '{1'b0, 4'hF,    32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF};
    tbl[8]  = '{1'b1, 4'b0011, 32'h0000_0024, 32'h0000_5566, 32'h0000_0000};
    tbl[9]  = '{1'b0, 4'hF,    32'h0000_0024, 32'h0000_0000, 32'hA5A5_5566};
    tbl[10] = '{1'b1, 4'b1000, 32'h0000_002B, 32'h7700_0000, 32'h0000_0000};
    tbl[11] = '{1'b0, 4'hF,    32'hFFFF_F028, 32'h0000_0000, 32'h77A5_000A};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      issue(1'b1, 4'hF, 32'(i * 4), 32'hA5A5_0000 + 32'(i));
    end
    repeat (LAT + 2) idle();

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Saturation: request held high for six reads, responses must come back in issue order.
    sat_exp[0] = 32'hDEAD_BEEF; sat_exp[1] = 32'hA5A5_0001; sat_exp[2] = 32'hA5A5_0002;
    sat_exp[3] = 32'hA5A5_0003; sat_exp[4] = 32'h11AA_3344; sat_exp[5] = 32'hA5A5_0005;
    got_q.delete();
    k = 0;
    guard = 0;
    while (k < 6 && guard < 100) begin
      cyc(1'b1, 1'b0, 4'hF, 32'(k * 4), 32'h0);
      if (last_dok === 1'b1) got_q.push_back(last_rd);
      if (last_aok) k++;
      guard++;
    end
    repeat (LAT + 2) begin
      idle();
      if (last_dok === 1'b1) got_q.push_back(last_rd);
    end
    chk("sat_issued", 32'(k), 32'd6);
`ifndef DSRAM_STALL_EN
    chk("sat_issue_cycles", 32'(guard), 32'd10);
`endif
    chk("sat_resp_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("sat_data%0d", i), (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF, sat_exp[i]);
    end

    // Reset with two reads in flight: nothing may be delivered afterwards, memory survives.
    issue(1'b0, 4'hF, 32'h0000_0004, 32'h0);
    issue(1'b0, 4'hF, 32'h0000_0008, 32'h0);
    do_reset();
    for (int i = 0; i < LAT + 3; i++) begin
      idle();
      chk("post_reset_quiet", {31'h0, last_dok}, 32'h0);
    end
    run_vec("post_reset_read", '{1'b0, 4'hF, 32'h0000_0004, 32'h0, 32'hA5A5_0001});

    // Random traffic confined to the initialised words, with random alias and lane bits.
    for (int i = 0; i < 600; i++) begin
      ra = $urandom();
      ra[AW+1:2] = AW'($urandom_range(0, 15));
      cyc(($urandom_range(0, 3) != 0), 1'($urandom()), 4'($urandom()), ra, $urandom());
    end
    repeat (LAT + 2) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_sram_like_slave.md
Name: data_sram_like_slave

Overview:
- Responder (slave) end of the data SRAM-like bus that the MEM stage consumes through data_sram_dataok/data_sram_rdata.
- Accepts requests with an addr_ok handshake, commits writes, and returns read data in order after a fixed LATENCY, with up to MAX_OUT requests in flight.
- Used as the on-chip data memory in the CPU simulation top and as the target for pipeline-stall verification.

Parameters:
ADDR_W, 10, word-address width; memory holds 2^ADDR_W 32-bit words
LATENCY, 2, cycles from acceptance (addr_ok&&req edge) to data_ok; legal range 1..8
MAX_OUT, 4, maximum outstanding accepted-but-not-responded requests; must be >= 1

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
data_sram_req  in  1  master request valid
data_sram_wr  in  1  1 = write, 0 = read
data_sram_size  in  2  0 = byte, 1 = half, 2 = word; informational, reads always return the full word
data_sram_wstrb  in  4  byte enables for writes; bit i enables byte lane i
data_sram_addr  in  32  byte address; word index = addr[ADDR_W+1:2], upper bits ignored (aliasing wrap)
data_sram_wdata  in  32  write data, lane-aligned
data_sram_addr_ok  out  1  request accepted this cycle (combinational)
data_sram_data_ok  out  1  one-cycle response pulse, in request order
data_sram_rdata  out  32  read data, valid only with data_ok

Behaviour:
- Reset (async): outstanding count = 0, response pipeline cleared, data_ok = 0, rdata = 0. Memory array is not reset.
- addr_ok = req && (count < MAX_OUT) [&& !stall when DSRAM_STALL_EN]. Same-cycle retire does not free a slot for acceptance.
- Acceptance = req && addr_ok at a posedge:
  - Write: masked bytes are written to mem[word index] at that edge. wstrb = 0 leaves memory unchanged.
  - Read: mem[word index] is sampled at that edge. It reflects all earlier accepted writes, not the same-cycle write of this request.
  - An entry {is_read, data} enters a LATENCY-deep in-order response pipeline.
- Response: entry accepted at edge T drives data_ok = 1 in the cycle following edge T+LATENCY-1, so data_ok is high LATENCY cycles after the accept cycle. The pulse is exactly one cycle.
  - rdata = sampled word for reads, 32'h0 for writes; rdata = 0 whenever data_ok = 0.
- No backpressure on responses: the master must take data_ok when it is asserted.
- Back-to-back accepts give back-to-back data_ok pulses in the same order.
- count: +1 on accept, -1 on data_ok. Accept and retire in the same cycle leave count unchanged. count never exceeds MAX_OUT.
- req dropped without addr_ok: nothing is recorded, no side effects.
- Address/wdata/wr/wstrb are sampled only at acceptance; changes while stalled are legal.
- Reset mid-operation: all in-flight responses are discarded with no data_ok afterwards. Writes already committed stay in memory.

Optional Feature:
- DSRAM_STALL_EN defined: a 16-bit Fibonacci LFSR with seed 16'hACE1 on reset.
  - Shifts left each cycle; new bit0 = b15^b13^b12^b10.
  - stall = (lfsr[1:0] == 2'b00); when stall is high, addr_ok is forced 0 regardless of capacity.
- DSRAM_STALL_EN undefined: no LFSR, stall = 0. addr_ok depends only on req and count.

Test Plan:
- Write: addr=32'h0000_0010, wdata=32'h1122_3344, wstrb=4'hF → addr_ok=1 in the request cycle; data_ok=1 two cycles later with rdata=0. Then read 32'h10 → data_ok after 2 cycles, rdata=32'h1122_3344.
- Partial write: wstrb=4'b0100, wdata=32'h00AA_0000 to addr 32'h10 → subsequent read returns 32'h11AA_3344. Write with wstrb=0 → read still returns 32'h11AA_3344.
- Saturation: req held high for 6 reads to addrs 0,4,8,C,10,14 (MAX_OUT=4, LATENCY=2) → count never exceeds 4; all 6 data_ok pulses return data in issue order; addr_ok is low only in cycles where count==4.
- Alias: write 32'hDEAD_BEEF to 32'h0000_1000 (ADDR_W=10) → read of 32'h0 returns 32'hDEAD_BEEF.
- Reset mid-flight: accept 2 reads, assert reset one cycle later → data_ok stays 0 thereafter, count=0; a post-reset read returns the pre-reset memory contents.
- With DSRAM_STALL_EN: constant req from reset → addr_ok is low exactly in cycles where the reference-model LFSR from seed 16'hACE1 has lfsr[1:0]==0; read data still matches memory.
